// File: rtl/pipeline_elastic.sv
// pipeline_elastic: parametrised valid/ready register pipeline with bubble collapse and synchronous flush.
// Latency: Depth cycles from acceptance to out_data when unstalled (Depth==0 is a combinational pass-through).
// Backpressure: the ready chain runs combinationally from out_ready, so a full pipe still accepts while draining.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   flush                 synchronous clear of all stages; blocks input while high
//   in_valid/in_ready/in_data     producer handshake
//   out_valid/out_ready/out_data  consumer handshake (stage Depth-1)
//   occupancy             number of valid stages (only with PIPELINE_ELASTIC_OCCUPANCY_EN defined)
//
// Parameters: Width (data bits), Depth (stages, 0 = pass-through), ResetData (1 = data flops reset to 0).
// Optional feature macro: PIPELINE_ELASTIC_OCCUPANCY_EN adds the occupancy counter port.
module pipeline_elastic #(
  parameter int Width     = 8,
  parameter int Depth     = 3,
  parameter int ResetData = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
  ,
  output logic [((Depth == 0) ? 1 : $clog2(Depth + 1))-1:0] occupancy
`endif
);

`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
  localparam int OccW = (Depth == 0) ? 1 : $clog2(Depth + 1);
`endif

  generate
    if (Depth == 0) begin : g_pass
      // No state: clock and reset are intentionally unused here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign out_valid = in_valid && !flush;
      assign out_data  = in_data;
      assign in_ready  = out_ready && !flush;

`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
      assign occupancy = '0;
`endif
    end else begin : g_pipe
      logic [Depth-1:0]            v;
      logic [Depth-1:0]            rdy;
      logic [Depth-1:0]            vin;
      logic [Depth-1:0][Width-1:0] d;
      logic [Depth-1:0][Width-1:0] din;
      logic                        in_fire;
      logic                        out_fire;

      // A stage can take new contents if it is empty or its successor can
      // take its contents; empty stages ahead of a stall let bubbles collapse.
      always_comb begin
        rdy            = '0;
        rdy[Depth-1]   = !v[Depth-1] || out_ready;
        for (int i = Depth - 2; i >= 0; i--) begin
          rdy[i] = !v[i] || rdy[i+1];
        end
      end

      assign in_ready  = rdy[0] && !flush;
      assign in_fire   = in_valid && in_ready;
      assign out_valid = v[Depth-1];
      assign out_data  = d[Depth-1];
      assign out_fire  = out_valid && out_ready;

      // Incoming contents for each stage: stage 0 from the producer, others
      // from their predecessor.
      always_comb begin
        vin    = '0;
        din    = '0;
        vin[0] = in_fire;
        din[0] = in_data;
        for (int i = 1; i < Depth; i++) begin
          vin[i] = v[i-1];
          din[i] = d[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v <= '0;
        end else if (flush) begin
          v <= '0;
        end else begin
          for (int i = 0; i < Depth; i++) begin
            if (rdy[i]) v[i] <= vin[i];
          end
        end
      end

      // Data only moves with a valid item; a bubble moves the valid bit alone.
      if (ResetData != 0) begin : g_dat_rst
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            d <= '0;
          end else begin
            for (int i = 0; i < Depth; i++) begin
              if (rdy[i] && vin[i]) d[i] <= din[i];
            end
          end
        end
      end else begin : g_dat_norst
        always_ff @(posedge clk) begin
          for (int i = 0; i < Depth; i++) begin
            if (rdy[i] && vin[i]) d[i] <= din[i];
          end
        end
      end

`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
      logic [OccW-1:0] occ;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          occ <= '0;
        end else if (flush) begin
          occ <= '0;
        end else if (in_fire && !out_fire) begin
          occ <= occ + OccW'(1);
        end else if (out_fire && !in_fire) begin
          occ <= occ - OccW'(1);
        end
      end

      assign occupancy = occ;

`ifndef SYNTHESIS
      a_occ_matches_valid : assert property (
        @(posedge clk) disable iff (!rst_n) occ == OccW'($countones(v))
      );
`endif
`endif
    end
  endgenerate

endmodule

// File: tb/tb_pipeline_elastic.sv
module tb_pipeline_elastic;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  logic       z_flush;
  logic       z_in_valid;
  logic       z_in_ready;
  logic [7:0] z_in_data;
  logic       z_out_valid;
  logic       z_out_ready;
  logic [7:0] z_out_data;

`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
  logic [1:0] occupancy;
  logic       z_occupancy;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_elastic #(.Width(8), .Depth(3), .ResetData(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  pipeline_elastic #(.Width(8), .Depth(0), .ResetData(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (z_flush),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .in_data   (z_in_data),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .out_data  (z_out_data)
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    ,
    .occupancy (z_occupancy)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 16);
      in_data  = 8'(c + 1);
      #1;
      if (c < 16) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      @(posedge clk); #1;
      if (c >= 2 && c <= 17) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_out_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_data !== 8'(c - 1)) begin errors++; $display("FAIL stream_out_data c=%0d got=%h exp=%h", c, out_data, 8'(c - 1)); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c=%0d got=%b exp=0", c, out_valid); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fill_stall();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready i=%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== 8'hA0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_head got=%b/%h exp=1/a0", out_valid, out_data); end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL full_occupancy got=%0d exp=3", occupancy); end
`endif
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA3;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_accept got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin errors++; $display("FAIL drain_order i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_seq[i]); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = 8'h22;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_accept got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("FAIL bubble_head got=%b/%h exp=1/11", out_valid, out_data); end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bubble_occupancy got=%0d exp=2", occupancy); end
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin errors++; $display("FAIL bubble_second got=%b/%h exp=1/22", out_valid, out_data); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + i);
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_in_ready got=%b exp=1", in_ready); end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
`endif
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin errors++; $display("FAIL flush_resume got=%b/%h exp=1/66", out_valid, out_data); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_resume_idle c=%0d got=%b exp=0", c, out_valid); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1;
    in_data = 8'h78;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin errors++; $display("FAIL areset_pre got=%b/%h exp=1/77", out_valid, out_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL areset_out_data got=%h exp=00", out_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_stale c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_depth0();
    logic exp_v, exp_r;
    for (int c = 0; c < 20; c++) begin
      z_flush     = (c % 5 == 3);
      z_in_valid  = 1'($urandom_range(0, 1));
      z_out_ready = 1'($urandom_range(0, 1));
      z_in_data   = 8'($urandom_range(0, 255));
      #1;
      exp_v = z_in_valid && !z_flush;
      exp_r = z_out_ready && !z_flush;
      checks++; if (z_out_valid !== exp_v) begin errors++; $display("FAIL d0_out_valid c=%0d got=%b exp=%b", c, z_out_valid, exp_v); end
      checks++; if (z_in_ready !== exp_r) begin errors++; $display("FAIL d0_in_ready c=%0d got=%b exp=%b", c, z_in_ready, exp_r); end
      checks++; if (z_out_data !== z_in_data) begin errors++; $display("FAIL d0_out_data c=%0d got=%h exp=%h", c, z_out_data, z_in_data); end
      @(posedge clk); #1;
    end
    z_flush = 1'b1; z_in_valid = 1'b1; z_out_ready = 1'b1;
    #1;
    checks++; if (z_out_valid !== 1'b0 || z_in_ready !== 1'b0) begin errors++; $display("FAIL d0_flush got=%b/%b exp=0/0", z_out_valid, z_in_ready); end
    z_flush = 1'b0;
  endtask

  initial begin
    z_flush = 1'b0; z_in_valid = 1'b0; z_in_data = 8'h00; z_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_fill_stall();
    test_bubble_collapse();
    test_flush();
    test_async_reset();
    test_depth0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
